// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the data-memory side of the SoC.
// Provides the default address/data widths, the strobe-width helper, the
// request struct layout and the holding-buffer state encoding.
package soc_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  // One strobe bit per data byte.
  function automatic int unsigned strb_w(input int unsigned dw);
    return dw / 8;
  endfunction

  localparam int unsigned BUS_SW = BUS_DW / 8;

  // Request fields at the default widths: valid, we, addr, wdata, wstrb.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wstrb;
  } bus_req_t;

  // Holding-buffer occupancy.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_PEND  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around dmem_arbiter: core data port (c_*), host/debug port
// (h_*) and the data-RAM port (m_*).
//   slave  : the arbiter's view (takes c_*/h_* requests and m_rdata,
//            drives c_rdata, host responses and the memory request)
//   master : the surrounding system's view (core, host and RAM)
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = soc_bus_pkg::strb_w(DW);

  logic          c_valid;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [SW-1:0] c_wstrb;
  logic [DW-1:0] c_rdata;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [SW-1:0] h_wstrb;
  logic          h_ready;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;

  logic          m_valid;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_valid, c_we, c_addr, c_wdata, c_wstrb,
    output c_rdata,
    input  h_req, h_we, h_addr, h_wdata, h_wstrb,
    output h_ready, h_rvalid, h_rdata,
    output m_valid, m_we, m_addr, m_wdata, m_wstrb,
    input  m_rdata
  );

  modport master (
    output c_valid, c_we, c_addr, c_wdata, c_wstrb,
    input  c_rdata,
    output h_req, h_we, h_addr, h_wdata, h_wstrb,
    input  h_ready, h_rvalid, h_rdata,
    input  m_valid, m_we, m_addr, m_wdata, m_wstrb,
    output m_rdata
  );

endinterface

// File: rtl/dmem_arbiter_bus_hold_reg.sv
// bus_hold_reg: one-entry holding buffer for host requests.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_req, in_*    : incoming host request and its fields
//   ready           : registered "buffer empty", never depends on in_req
//   issue           : buffered request is being sent to memory this cycle
//   pend            : buffer holds a request
//   hold_*          : buffered request fields
module bus_hold_reg
  import soc_bus_pkg::*;
#(
  parameter int unsigned AW = BUS_AW,
  parameter int unsigned DW = BUS_DW,
  parameter int unsigned SW = strb_w(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_req,
  input  logic          in_we,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [SW-1:0] in_wstrb,
  output logic          ready,
  input  logic          issue,
  output logic          pend,
  output logic          hold_we,
  output logic [AW-1:0] hold_addr,
  output logic [DW-1:0] hold_wdata,
  output logic [SW-1:0] hold_wstrb
);

  hold_state_e state, state_nxt;
  logic        accept;

  assign accept = in_req & ready;
  assign pend   = (state == HOLD_PEND);

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD_EMPTY: if (accept) state_nxt = HOLD_PEND;
      HOLD_PEND:  if (issue)  state_nxt = HOLD_EMPTY;
      default:    state_nxt = HOLD_EMPTY;
    endcase
  end

  // ready is a register copy of !pend so the host sees no path from h_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD_EMPTY;
      ready <= 1'b1;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == HOLD_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
    end else if (accept) begin
      hold_we    <= in_we;
      hold_addr  <= in_addr;
      hold_wdata <= in_wdata;
      hold_wstrb <= in_wstrb;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-RAM port between the rv32i core and a host
// master. The core has no stall, so it always wins and passes straight
// through; host requests wait in a one-entry buffer and go out in cycles
// where the core is idle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : c_* core port, h_* host port, m_* RAM port (slave view)
//   h_starved  : sticky, host deferred MAX_WAIT or more consecutive cycles
//   defer_cnt  : saturating total of cycles the host was deferred
module dmem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned AW       = BUS_AW,
  parameter int unsigned DW       = BUS_DW,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus,
  output logic             h_starved,
  output logic [CNT_W-1:0] defer_cnt
);

  localparam int unsigned SW     = strb_w(DW);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic          pend;
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [SW-1:0] hold_wstrb;
  logic          issue;
  logic          defer;
  logic [WAIT_W-1:0] wait_cnt;

  assign issue = pend & ~bus.c_valid;
  assign defer = pend &  bus.c_valid;

  bus_hold_reg #(
    .AW (AW),
    .DW (DW),
    .SW (SW)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_req     (bus.h_req),
    .in_we      (bus.h_we),
    .in_addr    (bus.h_addr),
    .in_wdata   (bus.h_wdata),
    .in_wstrb   (bus.h_wstrb),
    .ready      (bus.h_ready),
    .issue      (issue),
    .pend       (pend),
    .hold_we    (hold_we),
    .hold_addr  (hold_addr),
    .hold_wdata (hold_wdata),
    .hold_wstrb (hold_wstrb)
  );

  assign bus.c_rdata = bus.m_rdata;

  always_comb begin
    bus.m_valid = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    if (bus.c_valid) begin
      bus.m_valid = 1'b1;
      bus.m_we    = bus.c_we;
      bus.m_addr  = bus.c_addr;
      bus.m_wdata = bus.c_wdata;
      bus.m_wstrb = bus.c_wstrb;
    end else if (pend) begin
      bus.m_valid = 1'b1;
      bus.m_we    = hold_we;
      bus.m_addr  = hold_addr;
      bus.m_wdata = hold_wdata;
      bus.m_wstrb = hold_wstrb;
    end
  end

  // In an issue cycle the RAM is addressed by the buffer, so m_rdata is the
  // host's read data; writes complete with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.h_rvalid <= 1'b0;
      bus.h_rdata  <= '0;
    end else begin
      bus.h_rvalid <= issue;
      if (issue) bus.h_rdata <= hold_we ? '0 : bus.m_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defer_cnt <= '0;
      wait_cnt  <= '0;
      h_starved <= 1'b0;
    end else begin
      if (defer && defer_cnt != '1) defer_cnt <= defer_cnt + 1'b1;
      if (issue) begin
        wait_cnt <= '0;
      end else if (defer && wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      // Set on the deferral that takes the wait counter to MAX_WAIT.
      if (defer && wait_cnt >= WAIT_LIMIT - WAIT_W'(1)) h_starved <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        h_starved;
  logic [15:0] defer_cnt;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(
    .AW       (32),
    .DW       (32),
    .CNT_W    (16),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .h_starved (h_starved),
    .defer_cnt (defer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, synchronous-write RAM model.
  logic [31:0] mem [0:1023];
  assign bus.m_rdata = mem[bus.m_addr[11:2]];
  always @(posedge clk) begin
    if (bus.m_valid && bus.m_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_wstrb[b]) mem[bus.m_addr[11:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  function automatic logic [31:0] exp_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic bus_idle();
    bus.c_valid = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_wstrb = '0;
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0; bus.h_wstrb = '0;
  endtask

  task automatic apply_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [31:0] a, input logic [31:0] d);
    bus.c_valid = 1'b1; bus.c_we = 1'b1; bus.c_addr = a; bus.c_wdata = d; bus.c_wstrb = 4'hF;
    @(posedge clk);
    #1;
    bus.c_valid = 1'b0; bus.c_we = 1'b0;
  endtask

  // Presents a host request until accepted; returns in the cycle after the
  // accepting edge with h_req dropped. The expected response is queued.
  task automatic host_send(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd);
    int unsigned n = 0;
    bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d; bus.h_wstrb = s;
    while (!bus.h_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.h_ready) begin
      n_checks++; n_fail++;
      $display("FAIL host_accept_timeout h_ready=%b required=1", bus.h_ready);
    end else begin
      exp_q.push_back(exp_rd);
    end
    @(posedge clk);
    #1;
    bus.h_req = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL rst_h_ready got=%b exp=1", bus.h_ready); end
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_h_rvalid got=%b exp=0", bus.h_rvalid); end
    n_checks++; if (bus.h_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_h_rdata got=%h exp=0", bus.h_rdata); end
    n_checks++; if (h_starved !== 1'b0) begin n_fail++; $display("FAIL rst_h_starved got=%b exp=0", h_starved); end
    n_checks++; if (defer_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_defer_cnt got=%0d exp=0", defer_cnt); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
  endtask

  task automatic test_host_read();
    core_write(32'h100, 32'hDEADBEEF);
    host_send(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rd_m_valid got=%b exp=1", bus.m_valid); end
    n_checks++; if (bus.m_addr !== 32'h100) begin n_fail++; $display("FAIL rd_m_addr got=%h exp=100", bus.m_addr); end
    n_checks++; if (bus.m_we !== 1'b0) begin n_fail++; $display("FAIL rd_m_we got=%b exp=0", bus.m_we); end
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rvalid got=%b exp=0", bus.h_rvalid); end
    n_checks++; if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL rd_busy_ready got=%b exp=0", bus.h_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL rd_rdata got=%h exp=%h", bus.h_rdata, e); end
    n_checks++; if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_back got=%b exp=1", bus.h_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_pulse got=%b exp=0", bus.h_rvalid); end
    n_checks++; if (bus.h_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata_hold got=%h exp=deadbeef", bus.h_rdata); end
  endtask

  task automatic test_collision();
    apply_reset();
    core_write(32'h204, 32'hCAFEF00D);
    host_send(1'b1, 32'h200, 32'h11223344, 4'hF, 32'h0);
    bus.c_valid = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h204;
    #1;
    n_checks++; if (bus.m_addr !== 32'h204) begin n_fail++; $display("FAIL col_core_addr got=%h exp=204", bus.m_addr); end
    n_checks++; if (bus.m_we !== 1'b0) begin n_fail++; $display("FAIL col_core_we got=%b exp=0", bus.m_we); end
    n_checks++; if (bus.c_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL col_c_rdata got=%h exp=cafef00d", bus.c_rdata); end
    @(posedge clk); #1;
    n_checks++; if (defer_cnt !== 16'd1) begin n_fail++; $display("FAIL col_defer_cnt got=%0d exp=1", defer_cnt); end
    bus.c_valid = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h11223344)
      begin n_fail++; $display("FAIL col_issue got=%b/%b/%h/%h exp=1/1/200/11223344", bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata); end
    n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL col_early_rvalid got=%b exp=0", bus.h_rvalid); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL col_rvalid got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL col_rdata got=%h exp=%h", bus.h_rdata, e); end
    n_checks++; if (mem[32'h200 >> 2] !== 32'h11223344) begin n_fail++; $display("FAIL col_mem got=%h exp=11223344", mem[32'h200 >> 2]); end
  endtask

  task automatic test_back_pressure();
    host_send(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 32'h104; bus.h_wdata = 32'h77; bus.h_wstrb = 4'hF;
    n_checks++; if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got=%b exp=0", bus.h_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid_a got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL bp_rdata_a got=%h exp=%h", bus.h_rdata, e); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_latch got=%b exp=0", bus.m_valid); end
    n_checks++; if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b exp=1", bus.h_ready); end
    exp_q.push_back(32'h0);
    @(posedge clk); #1;
    bus.h_req = 1'b0;
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h104 || bus.m_wdata !== 32'h77)
      begin n_fail++; $display("FAIL bp_issue_b got=%b/%b/%h/%h exp=1/1/104/77", bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid_b got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL bp_rdata_b got=%h exp=%h", bus.h_rdata, e); end
    n_checks++; if (mem[32'h104 >> 2] !== 32'h77) begin n_fail++; $display("FAIL bp_mem got=%h exp=77", mem[32'h104 >> 2]); end
  endtask

  task automatic test_same_addr();
    host_send(1'b1, 32'h300, 32'h5555FFFF, 4'hF, 32'h0);
    bus.c_valid = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h300; bus.c_wdata = 32'hAAAA0000; bus.c_wstrb = 4'hF;
    @(posedge clk); #1;
    n_checks++; if (mem[32'h300 >> 2] !== 32'hAAAA0000) begin n_fail++; $display("FAIL sa_core_first got=%h exp=aaaa0000", mem[32'h300 >> 2]); end
    bus.c_valid = 1'b0; bus.c_we = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL sa_rvalid got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL sa_rdata got=%h exp=%h", bus.h_rdata, e); end
    n_checks++; if (mem[32'h300 >> 2] !== 32'h5555FFFF) begin n_fail++; $display("FAIL sa_final got=%h exp=5555ffff", mem[32'h300 >> 2]); end
  endtask

  task automatic test_starvation();
    apply_reset();
    host_send(1'b1, 32'h500, 32'h12345678, 4'hF, 32'h0);
    bus.c_valid = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h504;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_checks++; if (defer_cnt !== 16'(k)) begin n_fail++; $display("FAIL st_defer_%0d got=%0d exp=%0d", k, defer_cnt, k); end
      n_checks++; if (h_starved !== (k >= 4)) begin n_fail++; $display("FAIL st_starved_%0d got=%b exp=%b", k, h_starved, k >= 4); end
      n_checks++; if (bus.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL st_rvalid_%0d got=%b exp=0", k, bus.h_rvalid); end
    end
    bus.c_valid = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h500) begin n_fail++; $display("FAIL st_issue got=%b/%h exp=1/500", bus.m_valid, bus.m_addr); end
    @(posedge clk); #1;
    n_checks++; if (bus.h_rvalid !== 1'b1) begin n_fail++; $display("FAIL st_rvalid got=%b exp=1", bus.h_rvalid); end
    e = exp_pop();
    n_checks++; if (bus.h_rdata !== e) begin n_fail++; $display("FAIL st_rdata got=%h exp=%h", bus.h_rdata, e); end
    @(posedge clk); #1;
    n_checks++; if (h_starved !== 1'b1) begin n_fail++; $display("FAIL st_sticky got=%b exp=1", h_starved); end
    n_checks++; if (defer_cnt !== 16'd5) begin n_fail++; $display("FAIL st_defer_final got=%0d exp=5", defer_cnt); end
  endtask

  task automatic test_reset_mid_pend();
    int unsigned pulses = 0;
    apply_reset();
    core_write(32'h400, 32'hABCD0123);
    host_send(1'b1, 32'h400, 32'h1, 4'hF, 32'h0);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.h_rvalid) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rm_rvalid_pulses got=%0d exp=0", pulses); end
    n_checks++; if (mem[32'h400 >> 2] !== 32'hABCD0123) begin n_fail++; $display("FAIL rm_mem got=%h exp=abcd0123", mem[32'h400 >> 2]); end
    n_checks++; if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got=%b exp=1", bus.h_ready); end
    n_checks++; if (defer_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_defer_cnt got=%0d exp=0", defer_cnt); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_m_valid got=%b exp=0", bus.m_valid); end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_host_read();
    test_collision();
    test_back_pressure();
    test_same_addr();
    test_starvation();
    test_reset_mid_pend();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
